// File: rtl/uart_pkg.sv
// Shared UART definitions: parity/stop encodings, RX states and
// the data-width decode, used by both the RX and TX paths.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE  = 2'd0,
    PAR_ODD   = 2'd1,
    PAR_EVEN  = 2'd2,
    PAR_NONE3 = 2'd3
  } parity_t;

  typedef enum logic [1:0] {
    STOP_1   = 2'd0,
    STOP_1P5 = 2'd1,
    STOP_2   = 2'd2,
    STOP_1B  = 2'd3
  } stop_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam logic [15:0] MIN_DIV = 16'd4;

  function automatic logic [3:0] data_width(input logic [3:0] code);
    logic [3:0] w;
    case (code)
      4'd5, 4'd6, 4'd7: w = code;
      default:          w = 4'd8;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX line synchroniser, start-edge detect and bit sampler.
// UART_RX_MAJORITY_VOTE_EN selects 2-of-3 voting around mid-bit.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rx,
  input  logic        i_clr,
  input  logic [15:0] i_div,
  output logic        o_start_edge,
  output logic        o_bit_valid,
  output logic        o_bit_value
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_line_d;
  logic                   r_line_q;
  logic [15:0]            r_cnt;
  logic [15:0]            w_half;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_half = i_div >> 1;

  // r_line_d is the reference line; the extra stage lets the vote
  // see one sample past mid-bit without moving bit_valid.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync   <= '1;
      r_line_d <= 1'b1;
      r_line_q <= 1'b1;
      r_cnt    <= '0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], i_rx};
      r_line_d <= w_sync;
      r_line_q <= r_line_d;
      if (i_clr || (r_cnt == i_div - 16'd1))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_start_edge = r_line_q & ~r_line_d;
  assign o_bit_valid  = (r_cnt == w_half);

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic r_s0;
  logic r_s1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s0 <= 1'b1;
      r_s1 <= 1'b1;
    end else begin
      if (r_cnt == w_half - 16'd2)
        r_s0 <= w_sync;
      if (r_cnt == w_half - 16'd1)
        r_s1 <= w_sync;
    end
  end

  assign o_bit_value = (r_s0 & r_s1) |
                       (r_s0 & w_sync) |
                       (r_s1 & w_sync);
`else
  assign o_bit_value = r_line_d;
`endif

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: frame FSM, FIFO write and error counters.
// Optional UART_RX_MAJORITY_VOTE_EN enables 3-sample bit voting.
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CNT_W   = 4
) (
  input  logic                 sys_clk_i,
  input  logic                 rst_n_i,
  input  logic [3:0]           uart_data_bit_i,
  input  logic [15:0]          uart_bps_baud_cnt_max_i,
  input  logic [1:0]           uart_parity_bit_i,
  input  logic [1:0]           uart_stop_bit_i,
  input  logic                 rx_i,
  output logic                 fifo_uart_rx_wr_en_o,
  output logic [7:0]           fifo_uart_rx_din_o,
  input  logic                 fifo_uart_rx_prog_full_i,
  output logic [ERR_CNT_W-1:0] rx_parity_error_cnt_o,
  output logic [ERR_CNT_W-1:0] rx_frame_error_cnt_o,
  output logic [ERR_CNT_W-1:0] rx_overrun_cnt_o,
  output logic                 rx_busy_o
);

  localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

  rx_state_t r_state;
  rx_state_t w_state_nx;

  logic [15:0]          r_div;
  logic [3:0]           r_nbits;
  logic [1:0]           r_parity;
  logic [1:0]           r_stop;
  logic [2:0]           r_bit_idx;
  logic [7:0]           r_data;
  logic                 r_par_bit;
  logic                 r_stop_err;
  logic                 r_stop2;
  logic                 r_wr_en;
  logic [7:0]           r_din;
  logic [ERR_CNT_W-1:0] r_par_cnt;
  logic [ERR_CNT_W-1:0] r_frm_cnt;
  logic [ERR_CNT_W-1:0] r_ovr_cnt;

  logic w_start_edge;
  logic w_bit_valid;
  logic w_bit_value;
  logic w_latch;
  logic w_done;
  logic w_par_en;
  logic w_last_bit;
  logic w_stop_bad;
  logic w_par_bad;

  uart_rx_sampler #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sampler (
    .i_clk        (sys_clk_i),
    .i_rst_n      (rst_n_i),
    .i_rx         (rx_i),
    .i_clr        (w_latch),
    .i_div        (r_div),
    .o_start_edge (w_start_edge),
    .o_bit_valid  (w_bit_valid),
    .o_bit_value  (w_bit_value)
  );

  assign w_par_en   = (r_parity == PAR_ODD) ||
                      (r_parity == PAR_EVEN);
  assign w_last_bit = ({1'b0, r_bit_idx} == r_nbits - 4'd1);
  assign w_stop_bad = r_stop_err | ~w_bit_value;
  // Unused data bits stay 0, so a full-width XOR is exact.
  assign w_par_bad  = w_par_en &
                      ((^r_data ^ r_par_bit) ==
                       (r_parity == PAR_EVEN));

  always_comb begin
    w_state_nx = r_state;
    w_latch    = 1'b0;
    w_done     = 1'b0;
    unique case (r_state)
      RX_IDLE: begin
        if (w_start_edge) begin
          w_state_nx = RX_START;
          w_latch    = 1'b1;
        end
      end
      RX_START: begin
        if (w_bit_valid)
          w_state_nx = w_bit_value ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (w_bit_valid && w_last_bit)
          w_state_nx = w_par_en ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: begin
        if (w_bit_valid)
          w_state_nx = RX_STOP;
      end
      RX_STOP: begin
        if (w_bit_valid && (r_stop != STOP_2 || r_stop2)) begin
          w_state_nx = RX_IDLE;
          w_done     = 1'b1;
        end
      end
      default: w_state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (!rst_n_i)
      r_state <= RX_IDLE;
    else
      r_state <= w_state_nx;
  end

  always_ff @(posedge sys_clk_i) begin
    if (!rst_n_i) begin
      r_div      <= MIN_DIV;
      r_nbits    <= 4'd8;
      r_parity   <= '0;
      r_stop     <= '0;
      r_bit_idx  <= '0;
      r_data     <= '0;
      r_par_bit  <= 1'b0;
      r_stop_err <= 1'b0;
      r_stop2    <= 1'b0;
      r_wr_en    <= 1'b0;
      r_din      <= '0;
      r_par_cnt  <= '0;
      r_frm_cnt  <= '0;
      r_ovr_cnt  <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_latch) begin
        r_div      <= (uart_bps_baud_cnt_max_i < MIN_DIV) ?
                      MIN_DIV : uart_bps_baud_cnt_max_i;
        r_nbits    <= data_width(uart_data_bit_i);
        r_parity   <= uart_parity_bit_i;
        r_stop     <= uart_stop_bit_i;
        r_bit_idx  <= '0;
        r_data     <= '0;
        r_par_bit  <= 1'b0;
        r_stop_err <= 1'b0;
        r_stop2    <= 1'b0;
      end
      if (w_bit_valid && r_state == RX_DATA) begin
        r_data[r_bit_idx] <= w_bit_value;
        r_bit_idx         <= r_bit_idx + 3'd1;
      end
      if (w_bit_valid && r_state == RX_PARITY)
        r_par_bit <= w_bit_value;
      if (w_bit_valid && r_state == RX_STOP) begin
        r_stop_err <= w_stop_bad;
        r_stop2    <= 1'b1;
      end
      if (w_done) begin
        if (w_stop_bad) begin
          if (r_frm_cnt != '1)
            r_frm_cnt <= r_frm_cnt + CNT_ONE;
        end else if (w_par_bad) begin
          if (r_par_cnt != '1)
            r_par_cnt <= r_par_cnt + CNT_ONE;
        end else if (fifo_uart_rx_prog_full_i) begin
          if (r_ovr_cnt != '1)
            r_ovr_cnt <= r_ovr_cnt + CNT_ONE;
        end else begin
          r_wr_en <= 1'b1;
          r_din   <= r_data;
        end
      end
    end
  end

  assign fifo_uart_rx_wr_en_o  = r_wr_en;
  assign fifo_uart_rx_din_o    = r_din;
  assign rx_parity_error_cnt_o = r_par_cnt;
  assign rx_frame_error_cnt_o  = r_frm_cnt;
  assign rx_overrun_cnt_o      = r_ovr_cnt;
  assign rx_busy_o             = (r_state != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed self-checking bench for uart_rx_engine.
// Frames are driven bit-serially; writes are logged on negedge.
module tb_uart_rx_engine;

  localparam int CW = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx    = 1'b1;
  logic          pfull = 1'b0;
  logic [3:0]    dbits = 4'd8;
  logic [15:0]   div   = 16'd434;
  logic [1:0]    par   = 2'd0;
  logic [1:0]    stp   = 2'd0;
  logic [3:0]    nx_dbits = 4'd8;
  logic [1:0]    nx_par   = 2'd0;

  logic          wr_en;
  logic [7:0]    din;
  logic [CW-1:0] pcnt;
  logic [CW-1:0] fcnt;
  logic [CW-1:0] ocnt;
  logic          busy;

  int         n_checks = 0;
  int         n_err    = 0;
  int         wr_cnt   = 0;
  logic [7:0] got [0:63];

  always #10 clk = ~clk;

  uart_rx_engine #(
    .SYNC_STAGES (2),
    .ERR_CNT_W   (CW)
  ) dut (
    .sys_clk_i                (clk),
    .rst_n_i                  (rst_n),
    .uart_data_bit_i          (dbits),
    .uart_bps_baud_cnt_max_i  (div),
    .uart_parity_bit_i        (par),
    .uart_stop_bit_i          (stp),
    .rx_i                     (rx),
    .fifo_uart_rx_wr_en_o     (wr_en),
    .fifo_uart_rx_din_o       (din),
    .fifo_uart_rx_prog_full_i (pfull),
    .rx_parity_error_cnt_o    (pcnt),
    .rx_frame_error_cnt_o     (fcnt),
    .rx_overrun_cnt_o         (ocnt),
    .rx_busy_o                (busy)
  );

  always @(negedge clk) begin
    if (wr_en) begin
      if (wr_cnt < 64) got[wr_cnt] = din;
      wr_cnt++;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  // par: 0 none, 1 odd, 2 even; chg swaps in nx_* mid-data
  task automatic send_frame(input logic [7:0] d,
                            input int nb,
                            input int pm,
                            input bit flip,
                            input int nstop,
                            input bit stop_v,
                            input int bt,
                            input bit chg);
    logic [7:0] m;
    logic       p;
    m = 8'hFF >> (8 - nb);
    p = ^(d & m);
    if (pm == 1) p = ~p;
    rx = 1'b0;
    idle(bt);
    for (int i = 0; i < nb; i++) begin
      rx = d[i];
      if (chg && i == 2) begin
        dbits = nx_dbits;
        par   = nx_par;
      end
      idle(bt);
    end
    if (pm == 1 || pm == 2) begin
      rx = p ^ flip;
      idle(bt);
    end
    for (int s = 0; s < nstop; s++) begin
      rx = stop_v;
      idle(bt);
    end
    rx = 1'b1;
  endtask

  initial begin
    int base;
    idle(5);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_din",   32'(din),   32'd0);
    chk("rst_pcnt",  32'(pcnt),  32'd0);
    chk("rst_fcnt",  32'(fcnt),  32'd0);
    chk("rst_ocnt",  32'(ocnt),  32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    rst_n = 1'b1;
    idle(10);

    // 8N1 at D=434, two back-to-back bytes
    base = wr_cnt;
    send_frame(8'hA5, 8, 0, 0, 1, 1'b1, 434, 0);
    send_frame(8'h3C, 8, 0, 0, 1, 1'b1, 434, 0);
    idle(2 * 434);
    chk("basic_wr",   32'(wr_cnt - base), 32'd2);
    chk("basic_b0",   32'(got[base]),     32'hA5);
    chk("basic_b1",   32'(got[base + 1]), 32'h3C);
    chk("basic_pcnt", 32'(pcnt), 32'd0);
    chk("basic_fcnt", 32'(fcnt), 32'd0);
    chk("basic_ocnt", 32'(ocnt), 32'd0);

    // 5E2 at D=32
    div = 16'd32; dbits = 4'd5; par = 2'd2; stp = 2'd2;
    idle(64);
    base = wr_cnt;
    send_frame(8'h15, 5, 2, 0, 2, 1'b1, 32, 0);
    idle(64);
    chk("e5_wr",   32'(wr_cnt - base), 32'd1);
    chk("e5_byte", 32'(got[base]),     32'h15);
    base = wr_cnt;
    send_frame(8'h15, 5, 2, 1, 2, 1'b1, 32, 0);
    idle(64);
    chk("e5bad_wr",   32'(wr_cnt - base), 32'd0);
    chk("e5bad_pcnt", 32'(pcnt), 32'd1);
    chk("e5bad_din",  32'(din),  32'h15);

    // bad stop, then idle glitch
    dbits = 4'd8; par = 2'd0; stp = 2'd0;
    idle(64);
    base = wr_cnt;
    send_frame(8'h55, 8, 0, 0, 1, 1'b0, 32, 0);
    idle(64);
    chk("stop_fcnt", 32'(fcnt), 32'd1);
    chk("stop_wr",   32'(wr_cnt - base), 32'd0);
    rx = 1'b0;
    idle(10);
    rx = 1'b1;
    idle(96);
    chk("glitch_busy", 32'(busy), 32'd0);
    chk("glitch_fcnt", 32'(fcnt), 32'd1);
    chk("glitch_pcnt", 32'(pcnt), 32'd1);
    chk("glitch_wr",   32'(wr_cnt - base), 32'd0);

    // overrun, then frame counter saturation
    pfull = 1'b1;
    base  = wr_cnt;
    for (int k = 0; k < 3; k++) begin
      send_frame(8'h10 + 8'(k), 8, 0, 0, 1, 1'b1, 32, 0);
      idle(32);
    end
    idle(32);
    pfull = 1'b0;
    chk("ovr_ocnt", 32'(ocnt), 32'd3);
    chk("ovr_wr",   32'(wr_cnt - base), 32'd0);
    for (int k = 0; k < 20; k++) begin
      send_frame(8'hF0, 8, 0, 0, 1, 1'b0, 32, 0);
      idle(32);
    end
    idle(32);
    chk("sat_fcnt", 32'(fcnt), 32'd15);
    chk("sat_ocnt", 32'(ocnt), 32'd3);
    chk("sat_wr",   32'(wr_cnt - base), 32'd0);

    // 8O1 then 7E1 with no gap, config swapped mid-frame
    par = 2'd1; nx_dbits = 4'd7; nx_par = 2'd2;
    idle(64);
    base = wr_cnt;
    send_frame(8'h81, 8, 1, 0, 1, 1'b1, 32, 1);
    send_frame(8'h5A, 7, 2, 0, 1, 1'b1, 32, 0);
    idle(64);
    chk("b2b_wr",   32'(wr_cnt - base), 32'd2);
    chk("b2b_b0",   32'(got[base]),     32'h81);
    chk("b2b_b1",   32'(got[base + 1]), 32'h5A);
    chk("b2b_pcnt", 32'(pcnt), 32'd1);

    // reset in the middle of the data bits
    dbits = 4'd8; par = 2'd0; stp = 2'd0;
    idle(64);
    base = wr_cnt;
    rx = 1'b0; idle(32);
    rx = 1'b1; idle(32);
    rx = 1'b0; idle(32);
    rx = 1'b1; idle(16);
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    idle(3);
    chk("rstm_busy", 32'(busy), 32'd0);
    chk("rstm_pcnt", 32'(pcnt), 32'd0);
    chk("rstm_fcnt", 32'(fcnt), 32'd0);
    chk("rstm_ocnt", 32'(ocnt), 32'd0);
    rst_n = 1'b1;
    idle(96);
    chk("rstm_wr",    32'(wr_cnt - base), 32'd0);
    chk("rstm_busy2", 32'(busy), 32'd0);
    send_frame(8'hC3, 8, 0, 0, 1, 1'b1, 32, 0);
    idle(64);
    chk("post_wr",   32'(wr_cnt - base), 32'd1);
    chk("post_byte", 32'(got[base]),     32'hC3);
    chk("post_fcnt", 32'(fcnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
